// File: rtl/lif_pkg.sv
// lif_pkg
// Shared definitions for the time-multiplexed LIF neuron scheduler:
// the scan FSM state encoding and the default neuron constants used by
// lif_tdm_scheduler and lif_update_core.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_state_e;

    localparam int LIF_THRESHOLD  = 100;
    localparam int LIF_LEAK       = 2;
    localparam int LIF_REF_PERIOD = 10;

endpackage

// File: rtl/lif_update_core.sv
// lif_update_core
// Combinational leaky integrate-and-fire update for one neuron.
// Ports:
//   mem_i    current membrane value
//   refc_i   current refractory counter
//   cur_i    input current for this timestep
//   mem_o    next membrane value
//   refc_o   next refractory counter
//   spike_o  neuron fires this timestep
module lif_update_core
    import lif_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = LIF_THRESHOLD,
    parameter int LEAK       = LIF_LEAK,
    parameter int REF_PERIOD = LIF_REF_PERIOD,
    parameter int REF_W      = 4
) (
    input  logic [WIDTH-1:0] mem_i,
    input  logic [REF_W-1:0] refc_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] mem_o,
    output logic [REF_W-1:0] refc_o,
    output logic             spike_o
);

    localparam logic [WIDTH:0]   THR_V  = (WIDTH+1)'(THRESHOLD);
    localparam logic [WIDTH:0]   LEAK_V = (WIDTH+1)'(LEAK);
    localparam logic [REF_W-1:0] REF_V  = REF_W'(REF_PERIOD);

    // One extra bit so membrane + current never wraps before the compare.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, mem_i} + {1'b0, cur_i};

    always_comb begin
        mem_o   = '0;
        refc_o  = refc_i;
        spike_o = 1'b0;
        if (refc_i != '0) begin
            // Refractory: input is discarded and the membrane pinned at zero.
            refc_o = refc_i - REF_W'(1);
        end else if (sum >= THR_V) begin
            spike_o = 1'b1;
            refc_o  = REF_V;
        end else if (sum > LEAK_V) begin
            mem_o = WIDTH'(sum - LEAK_V);
        end
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler
// Scans NUM_NEURONS LIF neurons, one per cycle, on each tick. Spikes are
// emitted as indices on a valid/ready event port; a stalled event port
// freezes the scan until the pending event is taken.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   tick        start one timestep (ignored unless idle; sets overrun)
//   cur_addr    neuron index whose current is requested this cycle
//   cur_data    input current for cur_addr, same cycle
//   evt_valid, evt_ready, evt_addr  spike event output
//   busy        scan in progress (UPDATE or DONE)
//   done        one-cycle end-of-scan pulse
//   overrun     sticky: tick seen while not idle
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter  int NUM_NEURONS = 16,
    parameter  int WIDTH       = 8,
    parameter  int THRESHOLD   = LIF_THRESHOLD,
    parameter  int LEAK        = LIF_LEAK,
    parameter  int REF_PERIOD  = LIF_REF_PERIOD,
    localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic [IDX_W-1:0] cur_addr,
    input  logic [WIDTH-1:0] cur_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_addr,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int               REF_W    = (REF_PERIOD > 0) ? $clog2(REF_PERIOD + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    lif_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [NUM_NEURONS];
    logic [REF_W-1:0] ref_q [NUM_NEURONS];
    logic             evt_valid_q;
    logic [IDX_W-1:0] evt_addr_q;
    logic             overrun_q;

    logic             advance;
    logic             proc;
    logic [WIDTH-1:0] mem_nxt;
    logic [REF_W-1:0] ref_nxt;
    logic             spike;

    // The output slot can accept a new spike if it is empty or draining now.
    assign advance = !evt_valid_q || evt_ready;

    lif_update_core #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .LEAK       (LEAK),
        .REF_PERIOD (REF_PERIOD),
        .REF_W      (REF_W)
    ) u_core (
        .mem_i   (mem_q[idx_q]),
        .refc_i  (ref_q[idx_q]),
        .cur_i   (cur_data),
        .mem_o   (mem_nxt),
        .refc_o  (ref_nxt),
        .spike_o (spike)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        proc    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                if (advance) begin
                    proc = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
            evt_valid_q <= 1'b0;
            evt_addr_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (proc) begin
                mem_q[idx_q] <= mem_nxt;
                ref_q[idx_q] <= ref_nxt;
            end
            // A new spike wins over the drain of the previous event.
            if (proc && spike) begin
                evt_valid_q <= 1'b1;
                evt_addr_q  <= idx_q;
            end else if (evt_valid_q && evt_ready) begin
                evt_valid_q <= 1'b0;
            end
            if (tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign cur_addr  = idx_q;
    assign evt_valid = evt_valid_q;
    assign evt_addr  = evt_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler
// Directed self-checking bench for lif_tdm_scheduler with four neurons
// and default threshold, leak and refractory period.
module tb_lif_tdm_scheduler;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [1:0] cur_addr;
    logic [7:0] cur_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_addr;
    logic       busy;
    logic       done;
    logic       overrun;

    int errors;
    int checks;

    lif_tdm_scheduler #(
        .NUM_NEURONS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_addr  (evt_addr),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Expects events 0..3 on cycles T+2..T+5 (done with the last one),
    // then an empty event slot; called right after do_tick (cycle T+1).
    task automatic burst_check(input string tag);
        for (int k = 0; k < 4; k++) begin
            step();
            chk({tag, "_valid"}, 32'(evt_valid), 1);
            chk({tag, "_addr"}, 32'(evt_addr), 32'(k));
            chk({tag, "_done"}, 32'(done), (k == 3) ? 1 : 0);
        end
        step();
        chk({tag, "_drained"}, 32'(evt_valid), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        tick      = 1'b0;
        cur_data  = 8'd0;
        evt_ready = 1'b1;

        // Reset values
        do_reset();
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_addr", 32'(evt_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_cur_addr", 32'(cur_addr), 0);

        // Scan latency with zero current
        do_tick();
        chk("lat_busy_t1", 32'(busy), 1);
        chk("lat_cur_addr_t1", 32'(cur_addr), 0);
        step();
        step();
        step();
        chk("lat_done_t4", 32'(done), 0);
        step();
        chk("lat_done_t5", 32'(done), 1);
        chk("lat_busy_t5", 32'(busy), 1);
        step();
        chk("lat_done_t6", 32'(done), 0);
        chk("lat_busy_t6", 32'(busy), 0);
        chk("lat_no_evt", 32'(evt_valid), 0);

        // Integration: 20 per tick, leak 2 -> 18,36,54,72,90 then fire
        cur_data = 8'd20;
        for (int t = 1; t <= 5; t++) begin
            do_tick();
            for (int c = 0; c < 5; c++) begin
                step();
                chk("integ_no_evt", 32'(evt_valid), 0);
            end
        end
        do_tick();
        burst_check("integ_fire");

        // Backpressure on the first event
        do_reset();
        cur_data = 8'd255;
        do_tick();
        evt_ready = 1'b0;
        step();
        chk("bp_valid_t2", 32'(evt_valid), 1);
        chk("bp_addr_t2", 32'(evt_addr), 0);
        chk("bp_cur_addr_t2", 32'(cur_addr), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_hold_valid", 32'(evt_valid), 1);
            chk("bp_hold_addr", 32'(evt_addr), 0);
            chk("bp_hold_cur_addr", 32'(cur_addr), 1);
            chk("bp_hold_done", 32'(done), 0);
        end
        evt_ready = 1'b1;
        step();
        chk("bp_addr_t8", 32'(evt_addr), 1);
        chk("bp_cur_addr_t8", 32'(cur_addr), 2);
        step();
        chk("bp_addr_t9", 32'(evt_addr), 2);
        chk("bp_done_t9", 32'(done), 0);
        step();
        chk("bp_addr_t10", 32'(evt_addr), 3);
        chk("bp_valid_t10", 32'(evt_valid), 1);
        chk("bp_done_t10", 32'(done), 1);
        step();
        chk("bp_drained", 32'(evt_valid), 0);
        chk("bp_idle", 32'(busy), 0);

        // Refractory: fire on tick 1, silent for ticks 2..11, fire on tick 12
        do_reset();
        cur_data = 8'd255;
        do_tick();
        burst_check("ref_tick1");
        for (int t = 2; t <= 11; t++) begin
            do_tick();
            for (int c = 0; c < 5; c++) begin
                step();
                chk("ref_silent", 32'(evt_valid), 0);
            end
        end
        do_tick();
        burst_check("ref_tick12");

        // Tick during UPDATE is ignored and sets overrun
        do_tick();
        chk("ovr_pre", 32'(overrun), 0);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ovr_upd_flag", 32'(overrun), 1);
        chk("ovr_upd_busy", 32'(busy), 1);
        chk("ovr_upd_cur_addr", 32'(cur_addr), 2);
        step();
        chk("ovr_upd_cur_addr3", 32'(cur_addr), 3);
        step();
        chk("ovr_upd_done", 32'(done), 1);
        step();
        chk("ovr_upd_idle", 32'(busy), 0);
        chk("ovr_upd_sticky", 32'(overrun), 1);

        // Tick during DONE is ignored and sets overrun
        do_reset();
        chk("ovr_rst_clear", 32'(overrun), 0);
        do_tick();
        step();
        step();
        step();
        step();
        chk("ovr_done_state", 32'(done), 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ovr_done_flag", 32'(overrun), 1);
        chk("ovr_done_busy", 32'(busy), 0);
        chk("ovr_done_done", 32'(done), 0);
        step();
        step();
        chk("ovr_done_still_idle", 32'(busy), 0);
        chk("ovr_done_sticky", 32'(overrun), 1);

        // Reset mid-scan with an event pending at idx=2
        do_reset();
        cur_data  = 8'd255;
        evt_ready = 1'b0;
        do_tick();
        step();
        chk("mid_valid_t2", 32'(evt_valid), 1);
        chk("mid_cur_addr_t2", 32'(cur_addr), 1);
        evt_ready = 1'b1;
        step();
        chk("mid_addr_t3", 32'(evt_addr), 1);
        chk("mid_cur_addr_t3", 32'(cur_addr), 2);
        evt_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cur_addr", 32'(cur_addr), 0);
        chk("mid_rst_evt_addr", 32'(evt_addr), 0);
        chk("mid_rst_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_mem", 32'(dut.mem_q[i]), 0);
        end
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("mid_no_done", 32'(done), 0);
            chk("mid_no_busy", 32'(busy), 0);
        end
        // Refractory counters were cleared too: every neuron fires again.
        do_tick();
        burst_check("mid_refire");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
